master_spi: RTL and testbench
=============================

MASTER_SPI -- requirements
Module: master_spi

Interface
REQ-001 Parameter CLK_DIV, default 4, clk cycles per SCK half-period; legal range 1..255.
REQ-002 clk  input  1  system clock; all logic on posedge clk.
REQ-003 rst  input  1  synchronous reset, active-high.
REQ-004 start  input  1  one-cycle transfer request.
REQ-005 cpol  input  1  SCK idle level.
REQ-006 cpha  input  1  0 = sample on leading edge, 1 = sample on trailing edge.
REQ-007 data_in  input  8  byte to transmit, MSB first.
REQ-008 miso  input  1  serial data from slave.
REQ-009 sck  output  1  serial clock.
REQ-010 mosi  output  1  serial data to slave.
REQ-011 ss  output  1  slave select, active-low.
REQ-012 busy  output  1  transfer in progress.
REQ-013 done  output  1  one-cycle pulse at transfer end.
REQ-014 data_out  output  8  received byte.

Function
REQ-015 States SHALL be IDLE, LEAD, XFER and TRAIL; IDLE->LEAD on accepted start, LEAD->XFER after CLK_DIV cycles, XFER->TRAIL after 16th SCK edge, TRAIL->IDLE after CLK_DIV cycles.
REQ-016 start SHALL be accepted only in IDLE (busy=0); start while busy is ignored, with no effect on the current transfer.
REQ-017 On acceptance in cycle T: data_in, cpol and cpha latched; ss=0 and busy=1 from T+1; inputs may change after T without effect.
REQ-018 In IDLE and LEAD sck SHALL equal latched cpol; in XFER sck toggles every CLK_DIV cycles, 16 edges total, ending at cpol.
REQ-019 cpha=0: MSB on mosi from T+1; slave samples on leading edges; master samples miso on leading edges; mosi shifts on trailing edges.
REQ-020 cpha=1: mosi shifts on leading edges (first leading edge presents MSB); miso sampled on trailing edges.
REQ-021 Received bits SHALL shift in MSB first; data_out updates only in the done cycle and holds until next done or rst.
REQ-022 done=1 for exactly one cycle at T+1+18*CLK_DIV; in that cycle ss=1, busy=0; start in that cycle SHALL be accepted (back-to-back).
REQ-023 mosi SHALL hold its last value while ss=1 outside reset.
REQ-024 Divider counter SHALL be 8-bit, reload to CLK_DIV-1 on wrap; no off-by-one at CLK_DIV=1 (sck toggles every clk).

Reset
REQ-025 rst SHALL force, on the next posedge: state=IDLE, sck=0, latched cpol=0, cpha=0, ss=1, mosi=0, busy=0, done=0, data_out=8'h00, shift register and counters 0.
REQ-026 rst mid-transfer SHALL abort without done pulse and without updating data_out; rst dominates a simultaneous start.

Configuration
REQ-027 Macro MASTER_SPI_LSB_FIRST_EN: defined -> adds input lsb_first (1 bit, latched with start); lsb_first=1 sends and receives LSB first; undefined -> port absent, MSB first always, behaviour per REQ-019..021.

Structure
REQ-028 Package spi_pkg SHALL hold the state encoding (IDLE, LEAD, XFER, TRAIL), mode constants MODE0..MODE3 ({cpol,cpha}) and byte width 8.
REQ-029 Sub-module spi_clk_gen SHALL generate sck plus one-cycle lead_edge/trail_edge strobes from CLK_DIV, enable and cpol; master_spi instantiates it once.

Verification
REQ-030 CLK_DIV=4, mode 0, data_in=8'hA5, miso looped to mosi -> 16 sck edges, done at T+73, data_out=8'hA5.
REQ-031 Mode 3, data_in=8'h3C, slave model returns 8'hC3 -> mosi bits 0,0,1,1,1,1,0,0 on leading edges, data_out=8'hC3, sck idles 1.
REQ-032 CLK_DIV=1, mode 1, start asserted again in done cycle with data_in=8'h81 -> second transfer begins T+1 after done, ss high one cycle only.
REQ-033 start pulsed mid-transfer with data_in=8'hFF -> ignored; transmitted byte unchanged, exactly one done.
REQ-034 rst at 4th sck edge of transfer of 8'h55 -> next cycle ss=1, sck=0, busy=0, no done, data_out keeps previous value.
REQ-035 With MASTER_SPI_LSB_FIRST_EN, lsb_first=1, data_in=8'h01, loopback -> first mosi bit 1, data_out=8'h01.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared SPI master definitions: state encoding, mode constants, byte width
// and the bit-order helpers used by the transmit and receive shift registers.
`timescale 1ns/1ps
package spi_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEAD  = 2'd1,
        XFER  = 2'd2,
        TRAIL = 2'd3
    } state_e;

    // Modes are encoded as {cpol, cpha}
    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

    function automatic logic tx_bit(input logic [BYTE_W-1:0] sr, input logic lsb);
        return lsb ? sr[0] : sr[BYTE_W-1];
    endfunction

    function automatic logic [BYTE_W-1:0] tx_shift(input logic [BYTE_W-1:0] sr,
                                                   input logic lsb);
        return lsb ? {1'b0, sr[BYTE_W-1:1]} : {sr[BYTE_W-2:0], 1'b0};
    endfunction

    function automatic logic [BYTE_W-1:0] rx_shift(input logic [BYTE_W-1:0] sr,
                                                   input logic bit_in,
                                                   input logic lsb);
        return lsb ? {bit_in, sr[BYTE_W-1:1]} : {sr[BYTE_W-2:0], bit_in};
    endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// SCK generator: while enabled, toggles sck every CLK_DIV clk cycles and flags
// each toggle as a leading or trailing edge; while disabled, sck rests at cpol.
`timescale 1ns/1ps
module spi_clk_gen #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic cpol,
    output logic sck,
    output logic lead_edge,
    output logic trail_edge
);

    localparam logic [7:0] RELOAD = 8'(CLK_DIV - 1);

    logic [7:0] cnt_q, cnt_d;
    logic       sck_q, sck_d;
    logic       wrap;

    always_comb begin
        wrap  = enable && (cnt_q == 8'd0);
        cnt_d = cnt_q;
        sck_d = sck_q;
        // Preloading while idle makes the first toggle land a full half-period in
        if (!enable) begin
            cnt_d = RELOAD;
            sck_d = cpol;
        end else if (wrap) begin
            cnt_d = RELOAD;
            sck_d = ~sck_q;
        end else begin
            cnt_d = cnt_q - 8'd1;
        end
    end

    assign lead_edge  = wrap && (sck_q == cpol);
    assign trail_edge = wrap && (sck_q != cpol);
    assign sck        = sck_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 8'd0;
            sck_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            sck_q <= sck_d;
        end
    end

endmodule

// File: rtl/master_spi.sv
// Single-byte SPI master, modes 0-3, SCK half-period of CLK_DIV clk cycles.
// Optional MASTER_SPI_LSB_FIRST_EN adds an lsb_first input latched with start.
`timescale 1ns/1ps
module master_spi
    import spi_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              cpol,
    input  logic              cpha,
    input  logic [BYTE_W-1:0] data_in,
`ifdef MASTER_SPI_LSB_FIRST_EN
    input  logic              lsb_first,
`endif
    input  logic              miso,
    output logic              sck,
    output logic              mosi,
    output logic              ss,
    output logic              busy,
    output logic              done,
    output logic [BYTE_W-1:0] data_out
);

    localparam logic [7:0] RELOAD = 8'(CLK_DIV - 1);

    state_e            state_q, state_d;
    logic              cpol_q, cpol_d;
    logic              cpha_q, cpha_d;
    logic              lsb_q, lsb_d;
    logic [BYTE_W-1:0] tx_q, tx_d;
    logic [BYTE_W-1:0] rx_q, rx_d;
    logic              mosi_q, mosi_d;
    logic              ss_q, ss_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [BYTE_W-1:0] data_out_q, data_out_d;
    logic [7:0]        wait_q, wait_d;
    logic [4:0]        edge_q, edge_d;

    logic lsb_sel;
    logic xfer_en;
    logic lead_edge;
    logic trail_edge;
    logic sample_ev;
    logic shift_ev;

`ifdef MASTER_SPI_LSB_FIRST_EN
    assign lsb_sel = lsb_first;
`else
    assign lsb_sel = 1'b0;
`endif

    assign xfer_en = (state_q == XFER);

    spi_clk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_gen (
        .clk        (clk),
        .rst        (rst),
        .enable     (xfer_en),
        .cpol       (cpol_d),
        .sck        (sck),
        .lead_edge  (lead_edge),
        .trail_edge (trail_edge)
    );

    always_comb begin
        state_d    = state_q;
        cpol_d     = cpol_q;
        cpha_d     = cpha_q;
        lsb_d      = lsb_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        mosi_d     = mosi_q;
        ss_d       = ss_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        data_out_d = data_out_q;
        wait_d     = wait_q;
        edge_d     = edge_q;

        // The final trailing edge of cpha=0 must not shift, so mosi keeps bit 0
        sample_ev = cpha_q ? trail_edge : lead_edge;
        shift_ev  = cpha_q ? lead_edge : (trail_edge && (edge_q != 5'd15));

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LEAD;
                    cpol_d  = cpol;
                    cpha_d  = cpha;
                    lsb_d   = lsb_sel;
                    ss_d    = 1'b0;
                    busy_d  = 1'b1;
                    wait_d  = RELOAD;
                    rx_d    = '0;
                    edge_d  = 5'd0;
                    if (!cpha) begin
                        mosi_d = tx_bit(data_in, lsb_sel);
                        tx_d   = tx_shift(data_in, lsb_sel);
                    end else begin
                        tx_d   = data_in;
                    end
                end
            end
            LEAD: begin
                if (wait_q == 8'd0) begin
                    state_d = XFER;
                end else begin
                    wait_d = wait_q - 8'd1;
                end
            end
            XFER: begin
                if (sample_ev) begin
                    rx_d = rx_shift(rx_q, miso, lsb_q);
                end
                if (shift_ev) begin
                    mosi_d = tx_bit(tx_q, lsb_q);
                    tx_d   = tx_shift(tx_q, lsb_q);
                end
                if (lead_edge || trail_edge) begin
                    edge_d = edge_q + 5'd1;
                    if (edge_q == 5'd15) begin
                        state_d = TRAIL;
                        wait_d  = RELOAD;
                    end
                end
            end
            TRAIL: begin
                if (wait_q == 8'd0) begin
                    state_d    = IDLE;
                    ss_d       = 1'b1;
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                    data_out_d = rx_q;
                end else begin
                    wait_d = wait_q - 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            lsb_q      <= 1'b0;
            tx_q       <= '0;
            rx_q       <= '0;
            mosi_q     <= 1'b0;
            ss_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            data_out_q <= '0;
            wait_q     <= 8'd0;
            edge_q     <= 5'd0;
        end else begin
            state_q    <= state_d;
            cpol_q     <= cpol_d;
            cpha_q     <= cpha_d;
            lsb_q      <= lsb_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            mosi_q     <= mosi_d;
            ss_q       <= ss_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            data_out_q <= data_out_d;
            wait_q     <= wait_d;
            edge_q     <= edge_d;
        end
    end

    assign mosi     = mosi_q;
    assign ss       = ss_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign data_out = data_out_q;

endmodule

// File: tb/tb_master_spi.sv
// Self-checking bench for master_spi: one instance at CLK_DIV=4, one at CLK_DIV=1,
// a behavioural SPI slave on the selected instance, table vectors plus corner cases.
`timescale 1ns/1ps
module tb_master_spi;
    import spi_pkg::*;

    logic       clk = 1'b0;
    logic       rst, start, cpol, cpha;
    logic [7:0] data_in;
    logic       sel;
    logic       loopback;
    logic       miso_sl;
    logic [7:0] slave_byte;
`ifdef MASTER_SPI_LSB_FIRST_EN
    logic       lsb_first;
`endif

    logic       sck_a, mosi_a, ss_a, busy_a, done_a;
    logic [7:0] dout_a;
    logic       sck_b, mosi_b, ss_b, busy_b, done_b;
    logic [7:0] dout_b;
    logic       miso_a, miso_b, start_a, start_b;
    logic       sck_s, mosi_s, ss_s, busy_s, done_s;
    logic [7:0] dout_s;

    always #5 clk = ~clk;

    assign miso_a  = loopback ? mosi_a : miso_sl;
    assign miso_b  = loopback ? mosi_b : miso_sl;
    assign start_a = start & ~sel;
    assign start_b = start & sel;
    assign sck_s   = sel ? sck_b  : sck_a;
    assign mosi_s  = sel ? mosi_b : mosi_a;
    assign ss_s    = sel ? ss_b   : ss_a;
    assign busy_s  = sel ? busy_b : busy_a;
    assign done_s  = sel ? done_b : done_a;
    assign dout_s  = sel ? dout_b : dout_a;

    master_spi #(.CLK_DIV(4)) u_dut_a (
        .clk      (clk),
        .rst      (rst),
        .start    (start_a),
        .cpol     (cpol),
        .cpha     (cpha),
        .data_in  (data_in),
`ifdef MASTER_SPI_LSB_FIRST_EN
        .lsb_first(lsb_first),
`endif
        .miso     (miso_a),
        .sck      (sck_a),
        .mosi     (mosi_a),
        .ss       (ss_a),
        .busy     (busy_a),
        .done     (done_a),
        .data_out (dout_a)
    );

    master_spi #(.CLK_DIV(1)) u_dut_b (
        .clk      (clk),
        .rst      (rst),
        .start    (start_b),
        .cpol     (cpol),
        .cpha     (cpha),
        .data_in  (data_in),
`ifdef MASTER_SPI_LSB_FIRST_EN
        .lsb_first(1'b0),
`endif
        .miso     (miso_b),
        .sck      (sck_b),
        .mosi     (mosi_b),
        .ss       (ss_b),
        .busy     (busy_b),
        .done     (done_b),
        .data_out (dout_b)
    );

    // Behavioural slave, evaluated on the falling clk edge away from DUT updates
    logic       prev_sck = 1'b0;
    logic       prev_ss  = 1'b1;
    logic [7:0] sl_tx    = 8'h00;
    logic [7:0] sl_rx    = 8'h00;
    int         edge_cnt = 0;
    int         done_cnt = 0;

    always @(negedge clk) begin
        if (done_s) done_cnt++;
        if (prev_ss && !ss_s) begin
            edge_cnt = 0;
            sl_rx    = 8'h00;
            sl_tx    = slave_byte;
            if (!cpha) begin
                miso_sl = sl_tx[7];
                sl_tx   = {sl_tx[6:0], 1'b0};
            end
        end else if (!ss_s && (sck_s != prev_sck)) begin
            edge_cnt++;
            if ((sck_s != cpol) ^ cpha) begin
                sl_rx = {sl_rx[6:0], mosi_s};
            end else begin
                miso_sl = sl_tx[7];
                sl_tx   = {sl_tx[6:0], 1'b0};
            end
        end
        prev_sck = sck_s;
        prev_ss  = ss_s;
    end

    int check_cnt = 0;
    int pass_cnt  = 0;

    task automatic check_output(input string name, input int actual, input int expected);
        check_cnt++;
        if (actual == expected) pass_cnt++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    endtask

    // Called just after a posedge; start is sampled by the next posedge (cycle T)
    task automatic apply_stimulus(input logic s, input logic [1:0] mode, input logic [7:0] d,
                                  input logic [7:0] sb, input logic lb);
        sel        = s;
        cpol       = mode[1];
        cpha       = mode[0];
        data_in    = d;
        slave_byte = sb;
        loopback   = lb;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start      = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int lat);
        lat = 0;
        while (done_s !== 1'b1 && lat < budget) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    typedef struct {
        logic       sel;
        logic [1:0] mode;
        logic [7:0] data;
        logic [7:0] sb;
        logic       lb;
        logic [7:0] exp_out;
        int         exp_lat;
    } vec_t;

    vec_t vecs[6];
    int   lat;
    int   n;
    int   dc0;

    initial begin
        vecs[0] = '{1'b0, MODE0, 8'hA5, 8'h00, 1'b1, 8'hA5, 72};
        vecs[1] = '{1'b0, MODE3, 8'h3C, 8'hC3, 1'b0, 8'hC3, 72};
        vecs[2] = '{1'b0, MODE1, 8'h5A, 8'h96, 1'b0, 8'h96, 72};
        vecs[3] = '{1'b0, MODE2, 8'hF0, 8'h0F, 1'b0, 8'h0F, 72};
        vecs[4] = '{1'b1, MODE0, 8'h81, 8'h00, 1'b1, 8'h81, 18};
        vecs[5] = '{1'b1, MODE1, 8'h7E, 8'h24, 1'b0, 8'h24, 18};

        rst = 1'b1; start = 1'b0; cpol = 1'b0; cpha = 1'b0; data_in = 8'h00;
        sel = 1'b0; loopback = 1'b0; miso_sl = 1'b0; slave_byte = 8'h00;
`ifdef MASTER_SPI_LSB_FIRST_EN
        lsb_first = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check_output("reset_ss",   ss_a,   1);
        check_output("reset_busy", busy_a, 0);
        check_output("reset_done", done_a, 0);
        check_output("reset_sck",  sck_a,  0);
        check_output("reset_mosi", mosi_a, 0);
        check_output("reset_dout", dout_a, 0);
        check_output("reset_ss_b", ss_b,   1);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Abort at the 4th SCK edge: no done, data_out untouched, idle outputs
        dc0 = done_cnt;
        apply_stimulus(1'b0, MODE0, 8'h55, 8'h00, 1'b1);
        n = 0;
        while (edge_cnt != 4 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_output("abort_edge4_reached", edge_cnt, 4);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_output("abort_ss",   ss_a,   1);
        check_output("abort_sck",  sck_a,  0);
        check_output("abort_busy", busy_a, 0);
        check_output("abort_done", done_a, 0);
        check_output("abort_dout", dout_a, 0);
        repeat (80) @(posedge clk);
        #1;
        check_output("abort_no_done", done_cnt, dc0);
        check_output("abort_stays_idle", busy_a, 0);

        for (int i = 0; i < 6; i++) begin
            dc0 = done_cnt;
            apply_stimulus(vecs[i].sel, vecs[i].mode, vecs[i].data, vecs[i].sb, vecs[i].lb);
            check_output($sformatf("v%0d_ss_low", i), ss_s, 0);
            check_output($sformatf("v%0d_busy", i), busy_s, 1);
            if (!vecs[i].mode[0])
                check_output($sformatf("v%0d_first_mosi", i), mosi_s, vecs[i].data[7]);
            wait_done(vecs[i].exp_lat + 10, lat);
            check_output($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
            check_output($sformatf("v%0d_done_ss", i), ss_s, 1);
            check_output($sformatf("v%0d_done_busy", i), busy_s, 0);
            check_output($sformatf("v%0d_data_out", i), dout_s, vecs[i].exp_out);
            check_output($sformatf("v%0d_slave_rx", i), sl_rx, vecs[i].data);
            check_output($sformatf("v%0d_edges", i), edge_cnt, 16);
            check_output($sformatf("v%0d_sck_idle", i), sck_s, vecs[i].mode[1]);
            @(posedge clk);
            #1;
            check_output($sformatf("v%0d_one_done", i), done_cnt, dc0 + 1);
            check_output($sformatf("v%0d_done_low", i), done_s, 0);
        end

        // rst dominates a simultaneous start and clears data_out
        sel = 1'b0; cpol = 1'b0; cpha = 1'b0; data_in = 8'hAA;
        rst = 1'b1; start = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0; start = 1'b0;
        check_output("rst_start_busy", busy_a, 0);
        check_output("rst_start_ss",   ss_a,   1);
        check_output("rst_start_dout", dout_a, 0);
        @(posedge clk);
        #1;
        check_output("rst_start_still_idle", busy_a, 0);

        // start while busy is ignored
        dc0 = done_cnt;
        apply_stimulus(1'b0, MODE0, 8'h3C, 8'h5A, 1'b0);
        repeat (30) @(posedge clk);
        #1;
        data_in = 8'hFF;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        data_in = 8'h00;
        wait_done(80, lat);
        check_output("busy_start_latency", lat + 31, 72);
        check_output("busy_start_slave_rx", sl_rx, 8'h3C);
        check_output("busy_start_dout", dout_a, 8'h5A);
        repeat (100) @(posedge clk);
        #1;
        check_output("busy_start_one_done", done_cnt, dc0 + 1);
        check_output("busy_start_idle", busy_a, 0);

        // Back-to-back at CLK_DIV=1: restart in the done cycle
        apply_stimulus(1'b1, MODE1, 8'h42, 8'hBD, 1'b0);
        wait_done(40, lat);
        check_output("b2b_first_latency", lat, 18);
        check_output("b2b_first_dout", dout_b, 8'hBD);
        data_in    = 8'h81;
        slave_byte = 8'h7E;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start      = 1'b0;
        check_output("b2b_ss_high_one_cycle", ss_b, 0);
        check_output("b2b_busy", busy_b, 1);
        wait_done(40, lat);
        check_output("b2b_second_latency", lat, 18);
        check_output("b2b_second_dout", dout_b, 8'h7E);
        check_output("b2b_second_slave_rx", sl_rx, 8'h81);

`ifdef MASTER_SPI_LSB_FIRST_EN
        lsb_first = 1'b1;
        apply_stimulus(1'b0, MODE0, 8'h01, 8'h00, 1'b1);
        lsb_first = 1'b0;
        check_output("lsb_first_mosi", mosi_a, 1);
        wait_done(82, lat);
        check_output("lsb_latency", lat, 72);
        check_output("lsb_dout", dout_a, 8'h01);
`endif

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
